iic_slave: RTL and testbench



---
 rtl/iic_pkg.sv | 30 +++
 rtl/iic_bus_sync.sv | 44 ++++
 rtl/iic_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_iic_slave.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared I2C definitions: FSM state encoding, address width and the TX byte selector.
package iic_pkg;

  localparam int unsigned ADDR_W = 7;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_RX       = 3'd3;
  localparam logic [2:0] S_RX_ACK   = 3'd4;
  localparam logic [2:0] S_TX       = 3'd5;
  localparam logic [2:0] S_TX_ACK   = 3'd6;

  typedef enum logic [2:0] {
    StIdle   = S_IDLE,
    StAddr   = S_ADDR,
    StAddrAck = S_ADDR_ACK,
    StRx     = S_RX,
    StRxAck  = S_RX_ACK,
    StTx     = S_TX,
    StTxAck  = S_TX_ACK
  } iic_state_e;

  // Byte to put on the bus for a read: local data when offered, filler otherwise.
  function automatic logic [7:0] tx_pick(input logic valid, input logic [7:0] data,
                                         input logic [7:0] idle);
    return valid ? data : idle;
  endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// SCL/SDA input synchronizers plus edge, START and STOP detection on the synced values.
module iic_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_pad,
  input  logic sda_pad,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  // Synchronizer chains reset to the idle (released, pulled-up) bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q      <= '1;
      sda_q      <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_q      <= {scl_q[SYNC_STAGES-2:0], scl_pad};
      sda_q      <= {sda_q[SYNC_STAGES-2:0], sda_pad};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s    = scl_q[SYNC_STAGES-1];
  assign sda_s    = sda_q[SYNC_STAGES-1];
  assign sda_sync = sda_s;
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SDA moving while SCL stays high is a bus condition, not data.
  assign start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/iic_slave.sv
// I2C target endpoint: address match, byte receive/transmit over a local handshake.
// Optional SCL clock stretching at data-starved byte boundaries: IIC_SLAVE_CLK_STRETCH_EN.
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR    = 7'h50,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [7:0]        IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  inout  wire        scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det
);

`ifdef IIC_SLAVE_CLK_STRETCH_EN
  localparam bit StretchEn = 1'b1;
`else
  localparam bit StretchEn = 1'b0;
`endif

  iic_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rw_q, rw_d, busy_q, busy_d;
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       hold_q, hold_d, ack_q, ack_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       start_det_q, start_det_d, stop_det_q, stop_det_d;

  logic       sda_s, scl_rise, scl_fall, start, stop;
  logic [7:0] tx_byte;

  iic_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_pad (scl),
    .sda_pad (sda),
    .sda_sync(sda_s),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .stop    (stop)
  );

  assign tx_byte = tx_pick(tx_valid, tx_data, IDLE_BYTE);

  // Next-state: bus conditions first, then per-state bit handling on SCL edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;
    hold_d      = hold_q;
    ack_d       = ack_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;

    if (!enable) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      hold_d   = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d     = StAddr;
      cnt_d       = 3'd0;
      done_d      = 1'b0;
      sda_oe_d    = 1'b0;
      scl_oe_d    = 1'b0;
      hold_d      = 1'b0;
      start_det_d = 1'b1;
    end else if (stop) begin
      state_d    = StIdle;
      sda_oe_d   = 1'b0;
      scl_oe_d   = 1'b0;
      hold_d     = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StAddr: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            done_d  = (cnt_q == 3'd7);
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d  = StAddrAck;
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              busy_d   = 1'b1;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd0;
            done_d   = 1'b0;
            if (!rw_q) begin
              state_d = StRx;
            end else begin
              state_d = StTx;
              if (StretchEn && !tx_valid) begin
                hold_d   = 1'b1;
                scl_oe_d = 1'b1;
              end else begin
                shift_d  = tx_byte;
                tx_req_d = 1'b1;
                sda_oe_d = ~tx_byte[7];
              end
            end
          end
        end
        StRx: begin
          if (hold_q) begin
            // Stretched byte end: deliver the byte and ACK once the sink is ready.
            if (rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              hold_d     = 1'b0;
              scl_oe_d   = 1'b0;
              sda_oe_d   = 1'b1;
              state_d    = StRxAck;
            end
          end else if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              done_d = 1'b1;
              ack_d  = rx_ready;
              if (rx_ready) begin
                rx_data_d  = {shift_q[6:0], sda_s};
                rx_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && done_q) begin
            cnt_d  = 3'd0;
            done_d = 1'b0;
            if (ack_q) begin
              state_d  = StRxAck;
              sda_oe_d = 1'b1;
            end else if (StretchEn) begin
              hold_d   = 1'b1;
              scl_oe_d = 1'b1;
            end else begin
              state_d  = StIdle;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = StRx;
          end
        end
        StTx: begin
          if (hold_q) begin
            if (tx_valid) begin
              shift_d  = tx_byte;
              tx_req_d = 1'b1;
              sda_oe_d = ~tx_byte[7];
              hold_d   = 1'b0;
              scl_oe_d = 1'b0;
            end
          end else if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              state_d  = StTxAck;
              sda_oe_d = 1'b0;
              cnt_d    = 3'd0;
              done_d   = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              cnt_d    = cnt_q + 3'd1;
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        StTxAck: begin
          if (scl_rise && !done_q) begin
            ack_d  = ~sda_s;
            done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (ack_q) begin
              state_d = StTx;
              cnt_d   = 3'd0;
              if (StretchEn && !tx_valid) begin
                hold_d   = 1'b1;
                scl_oe_d = 1'b1;
              end else begin
                shift_d  = tx_byte;
                tx_req_d = 1'b1;
                sda_oe_d = ~tx_byte[7];
              end
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State register; reset releases both bus lines asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      done_q      <= 1'b0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      hold_q      <= 1'b0;
      ack_q       <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      hold_q      <= hold_d;
      ack_q       <= ack_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
    end
  end

  // Open-drain pads: only ever pull low.
  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign scl       = scl_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign busy      = busy_q;
  assign rw        = rw_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: bit-banged I2C master, vector table of write transfers
// plus hand-written read, repeated-START and mid-transfer reset sequences.
module tb_iic_slave;

`ifdef IIC_SLAVE_CLK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic rx_ready = 1'b0;
  logic tx_valid = 1'b0;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  wire  scl, sda;
  logic [7:0] rx_data, tx_data;
  logic rx_valid, tx_req, busy, rw, start_det, stop_det;

  int checks = 0;
  int fails = 0;
  int rx_cnt = 0, tx_cnt = 0, sd_cnt = 0, pd_cnt = 0, sda_drv = 0, scl_drv = 0;
  int tx_base = 0;
  logic [7:0] rx_log [16];
  logic [7:0] tx_list [4];

  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (scl);
  pullup (sda);
  assign tx_data = tx_list[2'(tx_cnt - tx_base)];

  always #5 clk = ~clk;

  iic_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_req   (tx_req),
    .busy     (busy),
    .rw       (rw),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[4'(rx_cnt)] = rx_data;
      rx_cnt++;
    end
    if (tx_req) tx_cnt++;
    if (start_det) sd_cnt++;
    if (stop_det) pd_cnt++;
    if (sda === 1'b0 && !m_sda_low) sda_drv++;
    if (scl === 1'b0 && !m_scl_low) scl_drv++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quarter();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    while (scl !== 1'b1 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (scl !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL scl_release_timeout: scl=%b after %0d clks, required 1", scl, n);
    end
  endtask

  task automatic bus_start();
    m_sda_low = 1'b1; quarter();
    m_scl_low = 1'b1; quarter();
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0; quarter();
    m_scl_low = 1'b0; wait_scl_high(); quarter();
    m_sda_low = 1'b1; quarter();
    m_scl_low = 1'b1; quarter();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; quarter();
    m_scl_low = 1'b0; wait_scl_high(); quarter();
    m_sda_low = 1'b0; quarter();
  endtask

  task automatic put_bit(input logic b);
    m_sda_low = !b; quarter();
    m_scl_low = 1'b0; wait_scl_high(); quarter(); quarter();
    m_scl_low = 1'b1; quarter();
  endtask

  task automatic get_bit(output logic b);
    m_sda_low = 1'b0; quarter();
    m_scl_low = 1'b0; wait_scl_high(); quarter();
    b = sda; quarter();
    m_scl_low = 1'b1; quarter();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = !b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(!ack);
  endtask

  typedef struct {
    logic       en;
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic       aack;   // expected address ACK
    logic       dack;   // expected ACK of first data byte
    int         nrx;    // expected rx_valid pulses
    logic [7:0] last;   // expected final rx_data
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic a0, a1, a2;
    logic [7:0] d;
    int rxb, sdb, pdb, drvb, txb, scb;
    vec_t v;

    vecs[0] = '{en: 1'b1, addr: 8'hA0, d0: 8'h3C, d1: 8'h5A, rdy: 1'b1,
                aack: 1'b1, dack: 1'b1, nrx: 2, last: 8'h5A};
    vecs[1] = '{en: 1'b1, addr: 8'h51, d0: 8'h00, d1: 8'h00, rdy: 1'b1,
                aack: 1'b0, dack: 1'b0, nrx: 0, last: 8'h00};
    if (STRETCH)
      vecs[2] = '{en: 1'b1, addr: 8'hA0, d0: 8'h11, d1: 8'h22, rdy: 1'b0,
                  aack: 1'b1, dack: 1'b1, nrx: 2, last: 8'h22};
    else
      vecs[2] = '{en: 1'b1, addr: 8'hA0, d0: 8'h11, d1: 8'h22, rdy: 1'b0,
                  aack: 1'b1, dack: 1'b0, nrx: 0, last: 8'h00};
    vecs[3] = '{en: 1'b0, addr: 8'hA0, d0: 8'h3C, d1: 8'h5A, rdy: 1'b1,
                aack: 1'b0, dack: 1'b0, nrx: 0, last: 8'h00};
    vecs[4] = '{en: 1'b1, addr: 8'hA4, d0: 8'h99, d1: 8'h00, rdy: 1'b1,
                aack: 1'b0, dack: 1'b0, nrx: 0, last: 8'h00};
    tx_list = '{8'h00, 8'h00, 8'h00, 8'h00};

    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    chk("reset_outputs", {rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det}, 32'h0);
    chk("reset_sda_released", sda, 1'b1);
    chk("reset_scl_released", scl, 1'b1);
    rst_n = 1'b1;
    enable = 1'b1;
    quarter();

    // Write transfers from the vector table.
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      enable = v.en;
      rx_ready = v.rdy;
      quarter();
      rxb = rx_cnt; sdb = sd_cnt; pdb = pd_cnt; drvb = sda_drv;
`ifdef IIC_SLAVE_CLK_STRETCH_EN
      if (!v.rdy) fork
        begin
          repeat (400) @(posedge clk);
          #1 rx_ready = 1'b1;
        end
      join_none
`endif
      bus_start();
      put_byte(v.addr, a0);
      chk($sformatf("v%0d_addr_ack", k), a0, v.aack);
      chk($sformatf("v%0d_busy_after_addr", k), busy, v.aack);
      if (a0) begin
        chk($sformatf("v%0d_rw", k), rw, 1'b0);
        put_byte(v.d0, a1);
        chk($sformatf("v%0d_data0_ack", k), a1, v.dack);
        if (a1) begin
          put_byte(v.d1, a2);
          chk($sformatf("v%0d_data1_ack", k), a2, 1'b1);
        end
      end
      bus_stop();
      quarter();
      chk($sformatf("v%0d_rx_count", k), rx_cnt - rxb, v.nrx);
      if (v.nrx == 2) begin
        chk($sformatf("v%0d_rx_first", k), rx_log[4'(rxb)], v.d0);
        chk($sformatf("v%0d_rx_last", k), rx_data, v.last);
      end
      chk($sformatf("v%0d_busy_end", k), busy, 1'b0);
      chk($sformatf("v%0d_start_det", k), sd_cnt - sdb, v.en);
      chk($sformatf("v%0d_stop_det", k), pd_cnt - pdb, v.en);
      chk($sformatf("v%0d_slave_drove_sda", k), sda_drv != drvb, v.aack);
    end
    enable = 1'b1;
    rx_ready = 1'b1;

    // Read two bytes, ACK then NACK.
    tx_list = '{8'hC3, 8'h7E, 8'h00, 8'h00};
    tx_base = tx_cnt;
    tx_valid = 1'b1;
    quarter();
    txb = tx_cnt; pdb = pd_cnt;
    bus_start();
    put_byte(8'hA1, a0);
    chk("rd_addr_ack", a0, 1'b1);
    chk("rd_rw", rw, 1'b1);
    get_byte(d, 1'b1);
    chk("rd_byte0", d, 8'hC3);
    get_byte(d, 1'b0);
    chk("rd_byte1", d, 8'h7E);
    chk("rd_tx_req_count", tx_cnt - txb, 2);
    chk("rd_busy_after_nack", busy, 1'b0);
    bus_stop();
    quarter();
    chk("rd_sda_released", sda, 1'b1);
    chk("rd_stop_det", pd_cnt - pdb, 1);

    // Read with no local data offered.
    tx_list = '{8'h96, 8'h00, 8'h00, 8'h00};
    tx_base = tx_cnt;
    tx_valid = 1'b0;
    quarter();
    txb = tx_cnt; scb = scl_drv;
`ifdef IIC_SLAVE_CLK_STRETCH_EN
    fork
      begin
        repeat (500) @(posedge clk);
        #1 tx_valid = 1'b1;
      end
    join_none
`endif
    bus_start();
    put_byte(8'hA1, a0);
    chk("idle_addr_ack", a0, 1'b1);
    get_byte(d, 1'b0);
    chk("idle_byte", d, STRETCH ? 8'h96 : 8'hFF);
    chk("idle_tx_req_count", tx_cnt - txb, 1);
    chk("idle_scl_stretched", scl_drv != scb, STRETCH);
    bus_stop();
    tx_valid = 1'b1;

    // Write then repeated START into a read.
    tx_list = '{8'h5A, 8'h00, 8'h00, 8'h00};
    tx_base = tx_cnt;
    quarter();
    sdb = sd_cnt;
    bus_start();
    put_byte(8'hA0, a0);
    chk("sr_wr_addr_ack", a0, 1'b1);
    chk("sr_rw_write", rw, 1'b0);
    put_byte(8'h10, a1);
    chk("sr_wr_data_ack", a1, 1'b1);
    chk("sr_rx_data", rx_data, 8'h10);
    bus_rstart();
    put_byte(8'hA1, a0);
    chk("sr_rd_addr_ack", a0, 1'b1);
    chk("sr_rw_read", rw, 1'b1);
    get_byte(d, 1'b0);
    chk("sr_rd_byte", d, 8'h5A);
    bus_stop();
    quarter();
    chk("sr_start_det_count", sd_cnt - sdb, 2);

    // Reset in the middle of a read byte of zeros.
    tx_list = '{8'h00, 8'h00, 8'h00, 8'h00};
    tx_base = tx_cnt;
    quarter();
    bus_start();
    put_byte(8'hA1, a0);
    chk("mr_addr_ack", a0, 1'b1);
    for (int i = 0; i < 3; i++) get_bit(a1);
    chk("mr_slave_driving", sda, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sda_released", sda, 1'b1);
    chk("mr_outputs_cleared", {rx_data, rx_valid, tx_req, busy, rw, start_det, stop_det}, 32'h0);
    m_sda_low = 1'b0;
    quarter();
    m_scl_low = 1'b0;
    quarter();
    rst_n = 1'b1;
    quarter();
    rxb = rx_cnt; sdb = sd_cnt;
    bus_start();
    put_byte(8'hA0, a0);
    chk("mr_next_addr_ack", a0, 1'b1);
    put_byte(8'h77, a1);
    chk("mr_next_data_ack", a1, 1'b1);
    bus_stop();
    quarter();
    chk("mr_next_rx_count", rx_cnt - rxb, 1);
    chk("mr_next_rx_data", rx_data, 8'h77);
    chk("mr_next_start_det", sd_cnt - sdb, 1);
    chk("mr_busy_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
